// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter that funnels per-thread LSU load/store requests onto a single
// data-memory port, one transaction in flight, and routes the response back to the granted LSU.
module lsu_mem_arbiter #(
   parameter int NUM_CHANNELS    = 4,
   parameter int DATA_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH      = 16
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [NUM_CHANNELS-1:0]                   read_req_val,
   input  logic [NUM_CHANNELS*DATA_ADDR_WIDTH-1:0]   read_req_addr,
   output logic [NUM_CHANNELS-1:0]                   read_req_rdy,
   input  logic [NUM_CHANNELS-1:0]                   read_resp_rdy,
   output logic [DATA_WIDTH-1:0]                     read_resp_data,
   output logic [NUM_CHANNELS-1:0]                   read_resp_data_val,
   input  logic [NUM_CHANNELS-1:0]                   write_req_val,
   input  logic [NUM_CHANNELS*DATA_ADDR_WIDTH-1:0]   write_req_addr,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]        write_req_data,
   output logic [NUM_CHANNELS-1:0]                   write_req_rdy,
   output logic [NUM_CHANNELS-1:0]                   write_resp_val,
   output logic                                      mem_req_val,
   input  logic                                      mem_req_rdy,
   output logic                                      mem_req_we,
   output logic [DATA_ADDR_WIDTH-1:0]                mem_req_addr,
   output logic [DATA_WIDTH-1:0]                     mem_req_wdata,
   input  logic                                      mem_resp_val,
   input  logic [DATA_WIDTH-1:0]                     mem_resp_data
);

   localparam int PW = $clog2(NUM_CHANNELS);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                   state, state_next;
   logic [PW-1:0]            ptr, gnt, sel, ptr_inc;
   logic                     found;
   logic [NUM_CHANNELS-1:0]  req, busy, gnt_onehot;
   logic                     sel_rd;
   logic [DATA_ADDR_WIDTH-1:0] sel_raddr, sel_waddr;
   logic [DATA_WIDTH-1:0]    sel_wdata;

   assign req = read_req_val | write_req_val;

   // First requesting channel at or after the round-robin pointer, wrapping.
   always_comb begin
      int idx;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         idx = (int'(ptr) + k) % NUM_CHANNELS;
         if (!found && req[PW'(idx)]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
   end

   assign ptr_inc = (sel == PW'(NUM_CHANNELS - 1)) ? '0 : sel + PW'(1);

   always_comb begin
      sel_rd    = 1'b0;
      sel_raddr = '0;
      sel_waddr = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (PW'(i) == sel) begin
            sel_rd    = read_req_val[i];
            sel_raddr = read_req_addr[i*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
            sel_waddr = write_req_addr[i*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
            sel_wdata = write_req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      gnt_onehot      = '0;
      gnt_onehot[gnt] = 1'b1;
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         busy[i] = reset || ((state != IDLE) && (gnt == PW'(i)));
      end
   end

   assign read_req_rdy  = ~busy;
   assign write_req_rdy = ~busy;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (found) state_next = ISSUE;
         ISSUE:   if (mem_req_val && mem_req_rdy) state_next = WAIT;
         WAIT:    if (mem_resp_val) state_next = RESP;
         RESP:    if (mem_req_we || read_resp_rdy[gnt]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request latch and registered responses; a read wins when both vals are set.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr                <= '0;
         gnt                <= '0;
         mem_req_val        <= 1'b0;
         mem_req_we         <= 1'b0;
         mem_req_addr       <= '0;
         mem_req_wdata      <= '0;
         read_resp_data     <= '0;
         read_resp_data_val <= '0;
         write_resp_val     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  gnt           <= sel;
                  ptr           <= ptr_inc;
                  mem_req_val   <= 1'b1;
                  mem_req_we    <= !sel_rd;
                  mem_req_addr  <= sel_rd ? sel_raddr : sel_waddr;
                  mem_req_wdata <= sel_wdata;
               end
            end
            ISSUE: begin
               if (mem_req_rdy) mem_req_val <= 1'b0;
            end
            WAIT: begin
               if (mem_resp_val) begin
                  if (mem_req_we) begin
                     write_resp_val <= gnt_onehot;
                  end else begin
                     read_resp_data     <= mem_resp_data;
                     read_resp_data_val <= gnt_onehot;
                  end
               end
            end
            RESP: begin
               if (mem_req_we) begin
                  write_resp_val <= '0;
               end else if (read_resp_rdy[gnt]) begin
                  read_resp_data_val <= '0;
                  read_resp_data     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
